// File: rtl/loop_nest_counter.sv
// Multi-level nested terminal counter with programmable per-level limits and
// one-shot or continuous restart. It sequences CNN loops such as kernel, row and channel.
module loop_nest_counter #(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        cont,
    input  logic [NUM_LEVELS*CNT_W-1:0] limit,
    input  logic                        advance,
    input  logic                        abort,
    output logic                        busy,
    output logic [NUM_LEVELS*CNT_W-1:0] cnt,
    output logic [NUM_LEVELS-1:0]       wrap,
    output logic                        done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                  r_state;
    logic                        r_cont;
    logic [NUM_LEVELS*CNT_W-1:0] r_limit;
    logic [NUM_LEVELS*CNT_W-1:0] r_cnt;
    logic [NUM_LEVELS-1:0]       r_wrap;
    logic                        r_done;

    logic [NUM_LEVELS:0]         w_carry;
    logic [NUM_LEVELS*CNT_W-1:0] w_step_cnt;
    logic [NUM_LEVELS-1:0]       w_step_wrap;

    // Level 0 always has a carry-in; gating by advance happens in the register update.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
            logic w_hit;
            assign w_hit            = (r_cnt[gi*CNT_W +: CNT_W] == r_limit[gi*CNT_W +: CNT_W]);
            assign w_step_wrap[gi]  = w_carry[gi] & w_hit;
            assign w_carry[gi+1]    = w_step_wrap[gi];
            assign w_step_cnt[gi*CNT_W +: CNT_W] =
                !w_carry[gi] ? r_cnt[gi*CNT_W +: CNT_W] :
                (w_hit ? '0 : r_cnt[gi*CNT_W +: CNT_W] + CNT_W'(1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cont  <= 1'b0;
            r_limit <= '0;
            r_cnt   <= '0;
            r_wrap  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_wrap <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_limit <= limit;
                        r_cont  <= cont;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (advance) begin
                        // A full-nest carry leaves every level at 0, ready for a restart.
                        r_cnt  <= w_step_cnt;
                        r_wrap <= w_step_wrap;
                        r_done <= w_carry[NUM_LEVELS];
                        if (w_carry[NUM_LEVELS] && !r_cont)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign cnt  = r_cnt;
    assign wrap = r_wrap;
    assign done = r_done;

endmodule

// File: doc/loop_nest_counter.md
Name: loop_nest_counter

Overview:
Parametrised multi-level terminal counter for CNN tile/loop sequencing, such as the kernel, row and channel loops. It generalises the single fixed-MAX counter in three ways: a run-time programmable limit per level, a nested carry chain across NUM_LEVELS levels, and one-shot or continuous mode. Each step is gated by a stall/advance input. The block sits beside the conv/pooling datapath and drives address generators, via cnt, and accumulator flush/valid logic, via wrap and done.

Parameters:
NUM_LEVELS, 3, number of nested counter levels; level 0 is innermost.
CNT_W, 16, width of each level's counter and limit.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  launch request; accepted only in IDLE.
cont  in  1  mode, sampled on accepted start; 1 = continuous (auto-restart), 0 = one-shot.
limit  in  NUM_LEVELS*CNT_W  terminal value per level; level i is at [i*CNT_W +: CNT_W]; level i counts 0..limit_i; sampled on accepted start.
advance  in  1  step enable while running; 0 = stall.
abort  in  1  cancel the run and return to IDLE.
busy  out  1  high while in RUN.
cnt  out  NUM_LEVELS*CNT_W  current count per level, same packing as limit.
wrap  out  NUM_LEVELS  one-cycle pulse; bit i = level i wrapped from limit_i to 0 on this step.
done  out  1  one-cycle pulse marking completion of a full nest (all levels wrapped together).

Behaviour:
- Reset (synchronous, highest priority): state IDLE; busy=0, cnt=0, wrap=0, done=0; latched limits and mode cleared.
- All outputs are registered and update on the clk edge after the qualifying input cycle.
- States: IDLE, RUN.
- IDLE:
  - start=1 and abort=0 -> latch limit and cont, cnt=0, go to RUN; busy=1 from the next cycle.
  - advance is ignored in IDLE, including in the start cycle.
  - start together with abort -> stay in IDLE.
- RUN, priority order abort > advance:
  - abort=1 -> cnt=0, wrap=0, done=0, go to IDLE; no done pulse.
  - advance=0 -> hold all counts; wrap=0, done=0.
  - advance=1 -> level 0 receives carry-in=1. For each level i with carry-in:
    - if cnt_i==limit_i: cnt_i=0, wrap[i]=1, carry to level i+1;
    - else: cnt_i=cnt_i+1, no further carry.
  - Levels without carry-in hold and report wrap[i]=0.
- Final step: carry out of level NUM_LEVELS-1 -> done=1 in the same cycle as wrap[NUM_LEVELS-1].
  - cont=0 -> next state IDLE, busy=0.
  - cont=1 -> stay in RUN with cnt=0 and the same latched limits.
- start in RUN is ignored. The limit and cont inputs are ignored outside an accepted start.
- limit_i=0: level i wraps on every carry-in.
- All limits 0: every advance produces done.
- Arithmetic is unsigned, CNT_W bits. cnt_i never exceeds limit_i, so there is no overflow.
- wrap and done are zero in every cycle without a qualifying advance.
- Steps per one-shot run = product over i of (limit_i+1), counted in advance cycles.
- Equivalence to the legacy single counter: limit_0=MAX-1, all other limits 0, cont=1, advance tied high -> wrap[0] and done pulse every MAX cycles.

Test Plan:
1. limits L0=31, L1=0, L2=0, cont=1, start, then advance held 1 -> wrap[0], wrap[1], wrap[2] and done pulse together once every 32 cycles; busy stays 1; cnt0 cycles 0..31.
2. limits L0=2, L1=1, L2=1, cont=0, advance held 1 -> 12 steps:
   - wrap[0] on steps 3, 6, 9, 12; wrap[1] on steps 6 and 12; wrap[2] and done on step 12;
   - busy=0 the cycle after step 12; cnt returns to 0.
3. Same limits as 2, advance pattern 1,0,0,1,0,1 -> cnt0 goes 1,1,1,2,2,0 and wrap[0] pulses only on the 6th cycle; counts hold during stalls.
4. Run from 2, abort asserted with advance=1 at cnt=(1,0,1) -> next cycle busy=0, cnt=0, wrap=0, no done pulse; a later start launches a fresh run from 0.
5. During RUN, start pulsed with new limits and the limit bus changed -> both ignored; the run finishes with the originally latched values (12 steps).
6. reset asserted for 1 cycle mid-run -> next edge all outputs 0, state IDLE. reset and start in the same cycle -> stay in IDLE, busy=0.
